// File: rtl/gate_vector_sequencer.sv
// Clocked stimulus/check sequencer for an and_nand + or_nor gate pair.
// Sweeps {in1,in0} through 00..11, checks the four responses and reports errors.
module gate_vector_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             in0,
  output logic             in1,
  input  logic             and_out,
  input  logic             nand_out,
  input  logic             or_out,
  input  logic             nor_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       err_vec,
  output logic [2:0]       fsm_state
);

  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PIDX_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [PIDX_W-1:0] LAST_PASS   = PIDX_W'(NUM_PASSES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    settle_cnt;
  logic [PIDX_W-1:0]   pass_idx;
  logic [1:0]          vec;
  logic [3:0]          exp_resp;
  logic                mismatch;

  // Expected response is derived from the registered stimulus, which equals vec in CHECK.
  always_comb begin
    exp_resp = {in1 & in0, ~(in1 & in0), in1 | in0, ~(in1 | in0)};
    mismatch = ({and_out, nand_out, or_out, nor_out} != exp_resp);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_APPLY;
      S_APPLY:  state_nxt = S_SETTLE;
      S_SETTLE: if (settle_cnt == '0) state_nxt = S_CHECK;
      S_CHECK:  begin
        if (vec != 2'd3 || pass_idx != LAST_PASS) state_nxt = S_APPLY;
        else                                      state_nxt = S_DONE;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      pass_idx   <= '0;
      vec        <= '0;
      in0        <= 1'b0;
      in1        <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      err_vec    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            err_count <= '0;
            err_vec   <= '0;
            pass      <= 1'b0;
            vec       <= '0;
            pass_idx  <= '0;
          end
        end
        S_APPLY: begin
          {in1, in0} <= vec;
          settle_cnt <= SETTLE_LOAD;
        end
        S_SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - CNT_W'(1);
        end
        S_CHECK: begin
          if (mismatch) begin
            if (err_count != '1) err_count <= err_count + ERR_W'(1);
            err_vec[vec] <= 1'b1;
          end
          // vec wraps 3 -> 0 naturally, which is also the start of the next pass.
          vec <= vec + 2'd1;
          if (vec == 2'd3 && pass_idx != LAST_PASS) pass_idx <= pass_idx + PIDX_W'(1);
        end
        S_DONE: begin
          pass       <= (err_count == '0);
          {in1, in0} <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == S_APPLY) || (state == S_SETTLE) || (state == S_CHECK);
  assign done      = (state == S_DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Bench for gate_vector_sequencer: three parameterisations driven by a faultable gate model,
// a table of full runs plus hand-written reset / start-collision sequences.
module tb_gate_vector_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int   sel  = 0;
  int   mode = 0;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  // Gate pair model; mode 1: nand stuck 1, 2: or stuck 0, 3: all inverted.
  function automatic logic [3:0] gates(input int m, input logic a1, input logic a0);
    logic [3:0] g;
    g = {a1 & a0, ~(a1 & a0), a1 | a0, ~(a1 | a0)};
    case (m)
      1: g[2] = 1'b1;
      2: g[1] = 1'b0;
      3: g = ~g;
      default: ;
    endcase
    return g;
  endfunction

  // Instance 0: defaults; 1: NUM_PASSES=3; 2: ERR_W=2, NUM_PASSES=2.
  logic       in0_a, in1_a, in0_b, in1_b, in0_c, in1_c;
  logic [3:0] g_a, g_b, g_c;
  logic       busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
  logic [7:0] err_a, err_b;
  logic [1:0] err_c;
  logic [3:0] vec_a, vec_b, vec_c;
  logic [2:0] st_a, st_b, st_c;

  assign g_a = gates(mode, in1_a, in0_a);
  assign g_b = gates(mode, in1_b, in0_b);
  assign g_c = gates(mode, in1_c, in0_c);

  gate_vector_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 0),
    .in0(in0_a), .in1(in1_a),
    .and_out(g_a[3]), .nand_out(g_a[2]), .or_out(g_a[1]), .nor_out(g_a[0]),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .err_vec(vec_a), .fsm_state(st_a)
  );

  gate_vector_sequencer #(.SETTLE_CYCLES(4), .NUM_PASSES(3), .ERR_W(8)) dut_p3 (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 1),
    .in0(in0_b), .in1(in1_b),
    .and_out(g_b[3]), .nand_out(g_b[2]), .or_out(g_b[1]), .nor_out(g_b[0]),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .err_vec(vec_b), .fsm_state(st_b)
  );

  gate_vector_sequencer #(.SETTLE_CYCLES(4), .NUM_PASSES(2), .ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 2),
    .in0(in0_c), .in1(in1_c),
    .and_out(g_c[3]), .nand_out(g_c[2]), .or_out(g_c[1]), .nor_out(g_c[0]),
    .busy(busy_c), .done(done_c), .pass(pass_c),
    .err_count(err_c), .err_vec(vec_c), .fsm_state(st_c)
  );

  logic       cur_busy, cur_done, cur_pass;
  logic [1:0] cur_in;
  logic [7:0] cur_err;
  logic [3:0] cur_vec;

  always_comb begin
    cur_busy = busy_a; cur_done = done_a; cur_pass = pass_a;
    cur_in = {in1_a, in0_a}; cur_err = err_a; cur_vec = vec_a;
    case (sel)
      1: begin
        cur_busy = busy_b; cur_done = done_b; cur_pass = pass_b;
        cur_in = {in1_b, in0_b}; cur_err = err_b; cur_vec = vec_b;
      end
      2: begin
        cur_busy = busy_c; cur_done = done_c; cur_pass = pass_c;
        cur_in = {in1_c, in0_c}; cur_err = {6'd0, err_c}; cur_vec = vec_c;
      end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Returns just after an active edge, i.e. observing the next cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance from cycle c until done is seen (c = that cycle) or the bound expires (c = 0).
  task automatic wait_done(input int c0, input int limit, output int c);
    c = c0;
    while (!cur_done && c < limit) begin
      tick();
      c++;
    end
    if (!cur_done) c = 0;
  endtask

  typedef struct {
    int         sel;
    int         mode;
    int         exp_cyc;
    int         exp_err;
    logic [3:0] exp_vec;
    logic       exp_pass;
  } run_t;

  // One full run: start sampled at edge 0; cycle c is observed just after edge c-1.
  task automatic run(input run_t r);
    int c;
    bit got;
    sel = r.sel; mode = r.mode;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 1; got = 0;
    while (!got && c < r.exp_cyc + 20) begin
      if (cur_done) got = 1;
      else begin
        if (c % 6 == 0) begin
          check("stim_vec", 32'(cur_in), 32'(((c / 6) - 1) % 4));
          check("busy_in_check", 32'(cur_busy), 32'd1);
        end
        tick();
        c++;
      end
    end
    check("done_cycle", got ? c : 0, r.exp_cyc);
    check("err_at_done", 32'(cur_err), r.exp_err);
    tick();
    check("done_one_cycle", 32'(cur_done), 32'd0);
    check("busy_after", 32'(cur_busy), 32'd0);
    check("pass", 32'(cur_pass), 32'(r.exp_pass));
    check("err_count", 32'(cur_err), r.exp_err);
    check("err_vec", 32'(cur_vec), 32'(r.exp_vec));
    check("stim_idle", 32'(cur_in), 32'd0);
  endtask

  run_t tbl[7];

  initial begin
    int c;
    int n_done;
    run_t golden;

    tbl[0] = '{0, 0, 25, 0, 4'b0000, 1'b1};
    tbl[1] = '{0, 1, 25, 1, 4'b1000, 1'b0};
    tbl[2] = '{0, 2, 25, 3, 4'b1110, 1'b0};
    tbl[3] = '{0, 3, 25, 4, 4'b1111, 1'b0};
    tbl[4] = '{1, 2, 73, 9, 4'b1110, 1'b0};
    tbl[5] = '{2, 3, 49, 3, 4'b1111, 1'b0};
    tbl[6] = '{1, 0, 73, 0, 4'b0000, 1'b1};
    golden = tbl[0];

    rst_n = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_pass", 32'(pass_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_vec", 32'(vec_a), 32'd0);
    check("rst_in", 32'({in1_a, in0_a}), 32'd0);
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) run(tbl[i]);

    // Reset during SETTLE of vector 10 (cycles 14..17) with failing gates.
    sel = 0; mode = 3;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i < 15; i++) tick();
    check("mid_err_before_rst", 32'(err_a), 32'd2);
    rst_n = 1'b0;
    tick();
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_err", 32'(err_a), 32'd0);
    check("mid_rst_vec", 32'(vec_a), 32'd0);
    check("mid_rst_in", 32'({in1_a, in0_a}), 32'd0);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      if (done_a || busy_a) n_done++;
      tick();
    end
    check("no_done_after_rst", n_done, 0);
    run(golden);

    // start pulsed while busy and during DONE is ignored.
    sel = 0; mode = 3;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(11, 60, c);
    check("busy_start_done_cycle", c, 25);
    start = 1'b1; tick(); start = 1'b0;
    check("done_start_busy", 32'(busy_a), 32'd0);
    check("done_start_err_hold", 32'(err_a), 32'd4);
    check("done_start_vec_hold", 32'(vec_a), 32'b1111);
    tick();
    check("done_start_no_run", 32'(busy_a), 32'd0);
    check("err_hold_idle", 32'(err_a), 32'd4);
    run(golden);

    // start held high: a new run starts from the first IDLE cycle.
    sel = 0; mode = 3;
    start = 1'b1; tick();
    wait_done(1, 60, c);
    check("held_done_cycle", c, 25);
    tick();
    check("held_idle_busy", 32'(busy_a), 32'd0);
    check("held_idle_err", 32'(err_a), 32'd4);
    tick();
    check("held_restart_busy", 32'(busy_a), 32'd1);
    check("held_restart_err_clr", 32'(err_a), 32'd0);
    check("held_restart_vec_clr", 32'(vec_a), 32'd0);
    start = 1'b0;
    wait_done(1, 60, c);
    check("held_second_done", c, 25);
    tick();
    check("held_second_err", 32'(err_a), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
